// File: rtl/logic_arbiter.sv
// logic_arbiter
//   Two requesters share one bitwise logic unit. A round-robin grant selects
//   one requester, and its result is captured in a one-entry output slot
//   (EMPTY/FULL). A new request can be accepted in the same cycle the slot
//   drains, so a steady rsp_ready gives one result per cycle.
//
//   Optional feature: define LOGIC_ARBITER_XOR_EN to execute op 11 as XOR.
//   Without it, op 11 is accepted normally and answered with data 0, err 1.
//
// Ports
//   clock                    sole clock, rising edge
//   reset                    asynchronous, active-high
//   reqN_valid/op/x/y        request N (N = 0,1); op 00 AND, 01 OR, 10 NOT x, 11 XOR/err
//   reqN_ready               combinational grant to requester N
//   rsp_valid/id/data/err    registered response slot
//   rsp_ready                consumer ready
module logic_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  input  logic             rsp_ready
);

`ifdef LOGIC_ARBITER_XOR_EN
  localparam logic XOR_EN = 1'b1;
`else
  localparam logic XOR_EN = 1'b0;
`endif

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             drain;
  logic             can_accept;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;
  logic             id_p1;
  logic [WIDTH-1:0] data_p1;
  logic             err_p1;

  function automatic logic [WIDTH-1:0] logic_result(input logic [1:0]       op,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
    case (op)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return ~x;
      default: return XOR_EN ? (x ^ y) : '0;
    endcase
  endfunction

  function automatic logic op_error(input logic [1:0] op);
    return (op == 2'b11) && !XOR_EN;
  endfunction

  // Lone requester wins; under contention the one not granted last wins.
  always_comb begin
    grant = ~last_grant;
    if (req0_valid && !req1_valid)
      grant = 1'b0;
    else if (req1_valid && !req0_valid)
      grant = 1'b1;
  end

  assign rsp_valid  = (state == FULL);
  assign drain      = rsp_valid & rsp_ready;
  assign can_accept = (state == EMPTY) | drain;

  // Readies are forced low while reset is held, even though the slot is EMPTY.
  assign req0_ready = can_accept & ~grant & ~reset;
  assign req1_ready = can_accept &  grant & ~reset;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign sel_op = grant ? req1_op : req0_op;
  assign sel_x  = grant ? req1_x  : req0_x;
  assign sel_y  = grant ? req1_y  : req0_y;

  // Stage p1: result slot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      id_p1      <= 1'b0;
      data_p1    <= '0;
      err_p1     <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) state <= FULL;
        FULL:  if (drain && !accept) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (accept) begin
        last_grant <= grant;
        id_p1      <= grant;
        data_p1    <= logic_result(sel_op, sel_x, sel_y);
        err_p1     <= op_error(sel_op);
      end
    end
  end

  assign rsp_id   = id_p1;
  assign rsp_data = data_p1;
  assign rsp_err  = err_p1;

endmodule
